// File: rtl/fetch_pkg.sv
// Shared types and helpers for the three-wide fetch queue: lane width, the
// {pc, instr} entry, and the valid-prefix length/mask helpers.
package fetch_pkg;

    localparam int FETCH_WIDTH = 3;
    localparam int INSTR_W     = 32;

    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Number of contiguous set bits starting at lane 0 (101 -> 1, 110 -> 0).
    function automatic logic [1:0] prefix_len(input logic [FETCH_WIDTH-1:0] v);
        if (!v[0])      return 2'd0;
        else if (!v[1]) return 2'd1;
        else if (!v[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    function automatic logic [FETCH_WIDTH-1:0] prefix_mask(input logic [1:0] n);
        case (n)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/fetch_compact.sv
// Valid-prefix and nop-squash compaction of one fetch group. Only used when
// FETCH_QUEUE_NOP_SQUASH_EN is defined.
import fetch_pkg::*;

module fetch_compact (
    input  logic [FETCH_WIDTH-1:0] valid_i,
    input  fetch_entry_t           lanes_i [FETCH_WIDTH],
    output fetch_entry_t           lanes_o [FETCH_WIDTH],
    output logic [1:0]             count_o
);

    logic [1:0] keep_n;
    logic [1:0] packed_n;

    // NOTE: every variable written here is given a default first, so no path
    // through the loop leaves one unassigned and no latch is inferred.
    always_comb begin
        lanes_o  = '{default: '0};
        packed_n = 2'd0;
        keep_n   = prefix_len(valid_i);
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (2'(k) < keep_n && lanes_i[k].instr != '0) begin
                lanes_o[packed_n] = lanes_i[k];
                packed_n          = packed_n + 2'd1;
            end
        end
        count_o = packed_n;
    end

endmodule

// File: rtl/fetch_queue.sv
// Three-wide in-order fetch->decode queue (circular buffer, explicit count).
// Optional nop squashing of fetched lanes: define FETCH_QUEUE_NOP_SQUASH_EN.
import fetch_pkg::*;

module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [FETCH_WIDTH-1:0] in_valid,
    input  logic [INSTR_W-1:0]     in_pc0,
    input  logic [INSTR_W-1:0]     in_pc1,
    input  logic [INSTR_W-1:0]     in_pc2,
    input  logic [INSTR_W-1:0]     in_instr0,
    input  logic [INSTR_W-1:0]     in_instr1,
    input  logic [INSTR_W-1:0]     in_instr2,
    output logic                   in_ready,
    output logic [FETCH_WIDTH-1:0] out_valid,
    output logic [INSTR_W-1:0]     out_pc0,
    output logic [INSTR_W-1:0]     out_pc1,
    output logic [INSTR_W-1:0]     out_pc2,
    output logic [INSTR_W-1:0]     out_instr0,
    output logic [INSTR_W-1:0]     out_instr1,
    output logic [INSTR_W-1:0]     out_instr2,
    input  logic [FETCH_WIDTH-1:0] out_take,
    output logic [PTR_W:0]         count
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] GROUP_C = (PTR_W+1)'(FETCH_WIDTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    fetch_entry_t     in_lanes   [FETCH_WIDTH];
    fetch_entry_t     enq_lanes  [FETCH_WIDTH];
    fetch_entry_t     head_lanes [FETCH_WIDTH];
    logic [1:0]       enq_avail, enq_n, deq_n, vis_n;

    assign in_lanes[0] = '{pc: in_pc0, instr: in_instr0};
    assign in_lanes[1] = '{pc: in_pc1, instr: in_instr1};
    assign in_lanes[2] = '{pc: in_pc2, instr: in_instr2};

`ifdef FETCH_QUEUE_NOP_SQUASH_EN
    fetch_compact u_compact (
        .valid_i (in_valid),
        .lanes_i (in_lanes),
        .lanes_o (enq_lanes),
        .count_o (enq_avail)
    );
`else
    assign enq_lanes = in_lanes;
    assign enq_avail = prefix_len(in_valid);
`endif

    // Status comes from registered count only; same-cycle pops never raise in_ready.
    assign in_ready  = (DEPTH_C - count_q) >= GROUP_C;
    assign vis_n     = (count_q >= GROUP_C) ? 2'd3 : count_q[1:0];
    assign out_valid = prefix_mask(vis_n);
    assign count     = count_q;

    assign enq_n = (in_ready && !flush) ? enq_avail : 2'd0;
    assign deq_n = flush ? 2'd0 : prefix_len(out_take & out_valid);

    always_comb begin
        head_d  = head_q + PTR_W'(deq_n);
        tail_d  = tail_q + PTR_W'(enq_n);
        count_d = count_q + (PTR_W+1)'(enq_n) - (PTR_W+1)'(deq_n);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_comb begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            head_lanes[k] = out_valid[k] ? mem_q[head_q + PTR_W'(k)] : '0;
        end
    end

    assign out_pc0    = head_lanes[0].pc;
    assign out_pc1    = head_lanes[1].pc;
    assign out_pc2    = head_lanes[2].pc;
    assign out_instr0 = head_lanes[0].instr;
    assign out_instr1 = head_lanes[1].instr;
    assign out_instr2 = head_lanes[2].instr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so stale
    // entries are never visible and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (2'(k) < enq_n) begin
                mem_q[tail_q + PTR_W'(k)] <= enq_lanes[k];
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus queues transactions, a negedge
// monitor compares head lanes/status against an expected-entry queue.
import fetch_pkg::*;

module tb_fetch_queue;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 flush = 1'b0;
    logic [2:0]           in_valid = '0;
    logic [31:0]          in_pc0 = '0, in_pc1 = '0, in_pc2 = '0;
    logic [31:0]          in_instr0 = '0, in_instr1 = '0, in_instr2 = '0;
    logic                 in_ready;
    logic [2:0]           out_valid;
    logic [31:0]          out_pc0, out_pc1, out_pc2;
    logic [31:0]          out_instr0, out_instr1, out_instr2;
    logic [2:0]           out_take = '0;
    logic [PTR_W:0]       count;

    fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_pc0     (in_pc0),
        .in_pc1     (in_pc1),
        .in_pc2     (in_pc2),
        .in_instr0  (in_instr0),
        .in_instr1  (in_instr1),
        .in_instr2  (in_instr2),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_pc0    (out_pc0),
        .out_pc1    (out_pc1),
        .out_pc2    (out_pc2),
        .out_instr0 (out_instr0),
        .out_instr1 (out_instr1),
        .out_instr2 (out_instr2),
        .out_take   (out_take),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]             valid;
        logic [2:0]             take;
        logic                   flush;
        fetch_entry_t [2:0]     lanes;
    } txn_t;

    txn_t         txn_q [$];
    fetch_entry_t exp_q [$];
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        in_valid = '0;
        out_take = '0;
        flush    = 1'b0;
    endtask

    // Drive one cycle of stimulus starting just after a rising edge, return just after the next.
    task automatic step_raw(input logic [2:0] v, input logic [31:0] pc,
                            input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] i2,
                            input logic [2:0] take, input logic fl);
        txn_t t;
        in_valid  = v;
        in_pc0    = pc;
        in_pc1    = pc + 32'd4;
        in_pc2    = pc + 32'd8;
        in_instr0 = i0;
        in_instr1 = i1;
        in_instr2 = i2;
        out_take  = take;
        flush     = fl;
        t.valid   = v;
        t.take    = take;
        t.flush   = fl;
        t.lanes[0] = '{pc: pc,          instr: i0};
        t.lanes[1] = '{pc: pc + 32'd4,  instr: i1};
        t.lanes[2] = '{pc: pc + 32'd8,  instr: i2};
        txn_q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [2:0] v, input logic [31:0] pc, input logic [2:0] take, input logic fl);
        step_raw(v, pc, 32'h2400_0000 | pc, 32'h2400_0004 | pc, 32'h2400_0008 | pc, take, fl);
    endtask

    // Monitor: compare head lanes and status, then apply the cycle's pops/pushes to the model.
    initial begin
        txn_t          t;
        int            n, vis, d, acc;
        logic          keep;
        logic [2:0]    mask;
        logic [31:0]   opc [3];
        logic [31:0]   oin [3];
        forever begin
            @(negedge clk);
            if (txn_q.size() != 0) begin
                t   = txn_q.pop_front();
                n   = exp_q.size();
                vis = (n >= 3) ? 3 : n;
                mask = 3'b000;
                for (int k = 0; k < 3; k++) if (k < vis) mask[k] = 1'b1;
                opc = '{out_pc0, out_pc1, out_pc2};
                oin = '{out_instr0, out_instr1, out_instr2};
                check("out_valid", 64'(out_valid), 64'(mask));
                check("count", 64'(count), 64'(n));
                check("in_ready", 64'(in_ready), 64'(n <= DEPTH - 3));
                for (int k = 0; k < 3; k++) begin
                    if (k < vis) begin
                        check($sformatf("lane%0d_pc", k), 64'(opc[k]), 64'(exp_q[k].pc));
                        check($sformatf("lane%0d_instr", k), 64'(oin[k]), 64'(exp_q[k].instr));
                    end else begin
                        check($sformatf("lane%0d_idle_zero", k), {opc[k], oin[k]}, 64'd0);
                    end
                end
                if (t.flush) begin
                    exp_q.delete();
                end else begin
                    d = 0;
                    for (int k = 0; k < 3; k++) if (k < vis && t.take[k] && d == k) d++;
                    repeat (d) void'(exp_q.pop_front());
                    if (n <= DEPTH - 3) begin
                        acc = 0;
                        for (int k = 0; k < 3; k++) begin
                            if (t.valid[k] && acc == k) begin
                                acc++;
                                keep = 1'b1;
`ifdef FETCH_QUEUE_NOP_SQUASH_EN
                                keep = (t.lanes[k].instr != 32'h0);
`endif
                                if (keep) exp_q.push_back(t.lanes[k]);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] pc;

        // Reset state
        #2;
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_pc0", 64'(out_pc0), 64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single group becomes visible one cycle later
        step(3'b111, 32'h0, 3'b000, 1'b0);
        check("grp_count", 64'(count), 64'd3);
        check("grp_out_valid", 64'(out_valid), 64'b111);
        check("grp_out_pc0", 64'(out_pc0), 64'h0);
        check("grp_in_ready", 64'(in_ready), 64'd1);

        // Fill to backpressure; third group is refused
        step(3'b111, 32'hC, 3'b000, 1'b0);
        check("fill_count", 64'(count), 64'd6);
        check("fill_in_ready", 64'(in_ready), 64'd0);
        step(3'b111, 32'h18, 3'b000, 1'b0);
        check("full_ignored_count", 64'(count), 64'd6);

        // Partial take (011) with interleaved groups; pointers wrap twice
        pc = 32'h18;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                step(3'b000, 32'h0, 3'b011, 1'b0);
            end else begin
                step(3'b111, pc, 3'b011, 1'b0);
                pc = pc + 32'd12;
            end
        end
        check("wrap_count", 64'(count), 64'd3);
        check("wrap_out_pc0", 64'(out_pc0), 64'h3C);
        check("wrap_out_pc2", 64'(out_pc2), 64'h44);

        // Non-prefix masks
        step(3'b101, 32'h48, 3'b000, 1'b0);
        check("mask101_count", 64'(count), 64'd4);
        step(3'b000, 32'h0, 3'b110, 1'b0);
        check("take110_count", 64'(count), 64'd4);
        check("take110_out_pc0", 64'(out_pc0), 64'h3C);

        // Flush with simultaneous enqueue and dequeue, then refill next cycle
        step(3'b001, 32'h4C, 3'b000, 1'b0);
        check("preflush_count", 64'(count), 64'd5);
        step(3'b111, 32'h50, 3'b111, 1'b1);
        check("flush_count", 64'(count), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        step(3'b111, 32'h60, 3'b000, 1'b0);
        check("refill_count", 64'(count), 64'd3);
        check("refill_out_pc0", 64'(out_pc0), 64'h60);

        // Asynchronous reset mid-cycle
        #2;
        idle();
        rst_n = 1'b0;
        #1;
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        check("async_rst_out_pc0", 64'(out_pc0), 64'd0);
        check("async_rst_out_instr0", 64'(out_instr0), 64'd0);
        exp_q.delete();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Nop lanes around a real instruction
        step_raw(3'b111, 32'h100, 32'h0000_0000, 32'h8C22_0004, 32'h0000_0000, 3'b000, 1'b0);
`ifdef FETCH_QUEUE_NOP_SQUASH_EN
        check("nop_count", 64'(count), 64'd1);
        check("nop_out_instr0", 64'(out_instr0), 64'h8C22_0004);
        check("nop_out_pc0", 64'(out_pc0), 64'h104);
`else
        check("nop_count", 64'(count), 64'd3);
        check("nop_out_instr0", 64'(out_instr0), 64'h0);
        check("nop_out_instr1", 64'(out_instr1), 64'h8C22_0004);
`endif

        // Drain
        step(3'b000, 32'h0, 3'b111, 1'b0);
        step(3'b000, 32'h0, 3'b111, 1'b0);
        check("drain_count", 64'(count), 64'd0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
